sync_memory: RTL and testbench

- Parametrised single-port synchronous data memory, successor to the current combinational memory block; sits between the datapath/load-store unit and storage.
- Adds a registered read with a valid strobe, per-byte write enables, address range checking with an error strobe, and an optional hardware zero-fill after reset behind a busy flag.
- Storage is written so synthesis infers block RAM; the array itself is never reset in parallel.

---
 rtl/sync_memory_pkg.sv | 18 +
 rtl/sync_memory.sv | 151 +++++++++++++++
 tb/tb_sync_memory.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_memory_pkg.sv
// Shared types and helpers for the synchronous data memory.
package sync_memory_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int bytes(input int d_size);
        return d_size / 8;
    endfunction

    function automatic bit params_ok(input int a_size, input int d_size, input int depth);
        return ((d_size % 8) == 0) && (d_size > 0) && (depth >= 1) &&
               (64'(depth) <= (64'd1 << a_size));
    endfunction

endpackage

// File: rtl/sync_memory.sv
// Single-port synchronous data memory: registered read with valid strobe,
// byte-enabled writes, range checking and optional zero-fill after reset.
module sync_memory
    import sync_memory_pkg::*;
#(
    parameter int A_SIZE        = 10,
    parameter int D_SIZE        = 32,
    parameter int DEPTH         = 1024,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [D_SIZE-1:0]     data_input,
    input  logic [A_SIZE-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [D_SIZE/8-1:0]   byte_en,
    output logic [D_SIZE-1:0]     data_output,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  error
);

    localparam int                NB        = bytes(D_SIZE);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A_SIZE:0]   DEPTH_W   = (A_SIZE + 1)'(DEPTH);
    localparam logic [A_SIZE-1:0] LAST_ADDR = A_SIZE'(DEPTH - 1);

    generate
        if (!params_ok(A_SIZE, D_SIZE, DEPTH)) begin : g_param_check
            $error("sync_memory: D_SIZE must be a multiple of 8 and DEPTH <= 2**A_SIZE");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [A_SIZE-1:0]   r_cnt;
    logic                w_in_range;
    logic                w_rd_ok;
    logic                w_reject;
    logic [NB-1:0]       w_mem_we;
    logic [IDX_W-1:0]    w_mem_addr;
    logic [D_SIZE-1:0]   w_mem_wdata;
    logic [D_SIZE-1:0]   r_mem [DEPTH];
    logic [D_SIZE-1:0]   r_data_output;
    logic                r_data_valid;
    logic                r_busy;
    logic                r_error;

    assign w_in_range = ({1'b0, address} < DEPTH_W);

    // State register and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (INIT_ON_RESET != 0) ? INIT : READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_cnt <= r_cnt + A_SIZE'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next state: leave INIT once the last word has been cleared.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                end else begin
                    w_state_nxt = INIT;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = READY;
        endcase
    end

    // Request decode and memory port steering; the fill owns the port during INIT.
    always_comb begin
        w_rd_ok     = 1'b0;
        w_reject    = 1'b0;
        w_mem_we    = '0;
        w_mem_addr  = address[IDX_W-1:0];
        w_mem_wdata = data_input;
        if (rst) begin
            w_rd_ok  = 1'b0;
            w_reject = 1'b0;
            w_mem_we = '0;
        end else begin
            case (r_state)
                INIT: begin
                    w_reject    = read | write;
                    w_mem_we    = '1;
                    w_mem_addr  = r_cnt[IDX_W-1:0];
                    w_mem_wdata = '0;
                end
                READY: begin
                    if (read && !write && w_in_range) begin
                        w_rd_ok = 1'b1;
                    end else if (write && !read && w_in_range) begin
                        w_mem_we = byte_en;
                    end else if (read || write) begin
                        w_reject = 1'b1;
                    end else begin
                        w_reject = 1'b0;
                    end
                end
                default: begin
                    w_reject = read | write;
                end
            endcase
        end
    end

    // One write port per byte lane; the array is never reset so it maps onto block RAM.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (w_mem_we[gi]) begin
                r_mem[w_mem_addr][gi*8 +: 8] <= w_mem_wdata[gi*8 +: 8];
            end
        end
    end

    // Registered read data and status strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_output <= '0;
            r_data_valid  <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= (INIT_ON_RESET != 0);
        end else begin
            r_data_valid <= w_rd_ok;
            r_error      <= w_reject;
            r_busy       <= (w_state_nxt == INIT);
            if (w_rd_ok) begin
                r_data_output <= r_mem[address[IDX_W-1:0]];
            end
        end
    end

    assign data_output = r_data_output;
    assign data_valid  = r_data_valid;
    assign busy        = r_busy;
    assign error       = r_error;

endmodule

// File: tb/tb_sync_memory.sv
// Self-checking bench for sync_memory: directed vector table, fill/reset
// sequences, and randomized traffic against a word-array reference model.
module tb_sync_memory;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst, rst_nf;
    logic [DW-1:0] din, din_nf;
    logic [AW-1:0] addr, addr_nf;
    logic          rd, wr, rd_nf, wr_nf;
    logic [3:0]    be, be_nf;
    logic [DW-1:0] dout, dout_nf;
    logic          valid, busy, err, valid_nf, busy_nf, err_nf;

    int n_checks = 0;
    int n_fail   = 0;

    sync_memory #(.A_SIZE(AW), .D_SIZE(DW), .DEPTH(DEPTH), .INIT_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .data_input(din), .address(addr), .read(rd), .write(wr),
        .byte_en(be), .data_output(dout), .data_valid(valid), .busy(busy), .error(err));

    sync_memory #(.A_SIZE(AW), .D_SIZE(DW), .DEPTH(DEPTH), .INIT_ON_RESET(0)) dut_nf (
        .clk(clk), .rst(rst_nf), .data_input(din_nf), .address(addr_nf), .read(rd_nf),
        .write(wr_nf), .byte_en(be_nf), .data_output(dout_nf), .data_valid(valid_nf),
        .busy(busy_nf), .error(err_nf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain word array plus the last value shown on data_output.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_out;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    be;
        logic          ev;
        logic          ee;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = (r & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
        end
        return r;
    endfunction

    // Apply one request to the model (READY state) and report expected outputs.
    task automatic model_apply(input logic r, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] b,
                               output logic ev, output logic ee, output logic [DW-1:0] ed);
        int ai;
        ai = int'(a);
        ev = 1'b0;
        ee = 1'b0;
        if (r && !w && ai < DEPTH) begin
            m_out = m_mem[ai];
            ev = 1'b1;
        end else if (w && !r && ai < DEPTH) begin
            m_mem[ai] = merge(m_mem[ai], d, b);
        end else if (r || w) begin
            ee = 1'b1;
        end
        ed = m_out;
    endtask

    task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] b);
        @(negedge clk);
        rst = 1'b0; rd = r; wr = w; addr = a; din = d; be = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd = 1'b0; wr = 1'b0; addr = '0; din = '0; be = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_error", {31'd0, err}, 32'd0);
        chk("rst_dout", dout, 32'd0);
    endtask

    // Count cycles with busy high, starting just after a reset edge; optionally
    // issue a write while busy and expect it to be rejected.
    task automatic count_busy(output int n, input int inject_at);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
            rst  = 1'b0;
            wr   = (k == inject_at);
            addr = '0; din = 32'hFFFF_FFFF; be = 4'hF; rd = 1'b0;
            @(posedge clk);
            #1;
            if (k == inject_at) begin
                chk("busy_wr_error", {31'd0, err}, 32'd1);
                chk("busy_wr_valid", {31'd0, valid}, 32'd0);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        logic          ev, ee;
        logic [DW-1:0] ed;
        int            nb;

        rst = 1'b0; rst_nf = 1'b1;
        idle_inputs();
        rd_nf = 1'b0; wr_nf = 1'b0; addr_nf = '0; din_nf = '0; be_nf = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_out = '0;

        vecs[0]  = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 6'd5,  32'h11223344, 4'h5, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 1'b1, 6'd3,  32'h12345678, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
        vecs[5]  = '{1'b1, 1'b0, 6'd3,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'h00000000};
        vecs[6]  = '{1'b1, 1'b0, 6'd20, 32'h00000000, 4'h0, 1'b0, 1'b1, 32'h00000000};
        vecs[7]  = '{1'b0, 1'b1, 6'd5,  32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h00000000};
        vecs[8]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[9]  = '{1'b0, 1'b1, 6'd40, 32'h55555555, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
        vecs[10] = '{1'b0, 1'b0, 6'd9,  32'h00000000, 4'h0, 1'b0, 1'b0, 32'hDE22BE44};
        vecs[11] = '{1'b0, 1'b1, 6'd7,  32'hCAFEF00D, 4'hA, 1'b0, 1'b0, 32'hDE22BE44};
        vecs[12] = '{1'b1, 1'b0, 6'd7,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'hCA00F000};
        vecs[13] = '{1'b0, 1'b1, 6'd15, 32'h0000FFFF, 4'h3, 1'b0, 1'b0, 32'hCA00F000};
        vecs[14] = '{1'b1, 1'b0, 6'd15, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h0000FFFF};
        vecs[15] = '{1'b1, 1'b0, 6'd16, 32'h00000000, 4'h0, 1'b0, 1'b1, 32'h0000FFFF};

        // Fill after reset: busy for exactly DEPTH cycles, then every word reads 0.
        reset_pulse();
        count_busy(nb, -1);
        chk("fill_busy_cycles", nb, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, AW'(i), '0, '0);
            chk("fill_read_valid", {31'd0, valid}, 32'd1);
            chk("fill_read_data", dout, 32'd0);
        end

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, ev, ee, ed);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_error", i), {31'd0, err}, {31'd0, vecs[i].ee});
            chk($sformatf("vec%0d_data", i), dout, vecs[i].ed);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic          r, w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [3:0]    b;
            int            op;
            op = $urandom_range(0, 9);
            r  = (op <= 3) || (op == 8);
            w  = ((op >= 4) && (op <= 7)) || (op == 8);
            a  = AW'($urandom_range(0, 21));
            d  = $urandom;
            b  = 4'($urandom_range(0, 15));
            step(r, w, a, d, b);
            model_apply(r, w, a, d, b, ev, ee, ed);
            chk("rnd_valid", {31'd0, valid}, {31'd0, ev});
            chk("rnd_error", {31'd0, err}, {31'd0, ee});
            chk("rnd_data", dout, ed);
            chk("rnd_exclusive", {31'd0, valid & err}, 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, AW'(i), '0, '0);
            model_apply(1'b1, 1'b0, AW'(i), '0, '0, ev, ee, ed);
            chk("readback_data", dout, ed);
        end

        // Reset at fill cycle 7 restarts the fill; a write while busy is rejected.
        reset_pulse();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("busy_mid_fill", {31'd0, busy}, 32'd1);
        reset_pulse();
        count_busy(nb, 10);
        chk("restart_busy_cycles", nb, DEPTH);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        step(1'b1, 1'b0, AW'(0), '0, '0);
        chk("busy_wr_dropped", dout, 32'd0);
        step(1'b1, 1'b0, AW'(5), '0, '0);
        chk("refill_word5", dout, 32'd0);

        // No-fill instance: ready immediately after reset.
        @(negedge clk);
        rst_nf = 1'b1;
        @(posedge clk);
        #1;
        chk("nf_busy", {31'd0, busy_nf}, 32'd0);
        chk("nf_dout_rst", dout_nf, 32'd0);
        @(negedge clk);
        rst_nf = 1'b0; wr_nf = 1'b1; addr_nf = '0; din_nf = 32'hA5A5A5A5; be_nf = 4'hF;
        @(posedge clk);
        #1;
        chk("nf_wr_error", {31'd0, err_nf}, 32'd0);
        @(negedge clk);
        wr_nf = 1'b0; rd_nf = 1'b1;
        @(posedge clk);
        #1;
        chk("nf_rd_valid", {31'd0, valid_nf}, 32'd1);
        chk("nf_rd_data", dout_nf, 32'hA5A5A5A5);
        @(negedge clk);
        rd_nf = 1'b0;
        @(posedge clk);
        #1;
        chk("nf_idle_valid", {31'd0, valid_nf}, 32'd0);
        chk("nf_idle_hold", dout_nf, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
